aim65_ram_dp: RTL and testbench
===============================

Name: aim65_ram_dp

Overview:
Parametrised dual-port RAM, successor to the single-port AIM65 work RAM.
- Port A serves the 6502 bus.
- Port B serves the MiSTer loader/debug path (ioctl download, memory viewer).
- A hardware init sequencer fills every word with a fill value after reset or on request, replacing simulation-only initialisation.
- Sits between the address decoder and CPU data mux; one instance per RAM bank.

Parameters:
ADDR_WIDTH, 16, address bus width of both ports
DATA_WIDTH, 8, word width
DEPTH, 1024, number of words implemented; must be <= 2**ADDR_WIDTH
FILL, 8'hFF, init/fill value, DATA_WIDTH bits
WP_BASE, 0, first write-protected word (only with AIM65_RAM_WP_EN)
WP_SIZE, 0, number of write-protected words; 0 = none (only with AIM65_RAM_WP_EN)

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
init_req  in  1  single-cycle pulse; starts a fill pass
busy  out  1  high while the init sequencer runs
cs  in  1  port A select
rw  in  1  port A: 1 = read, 0 = write
addr  in  ADDR_WIDTH  port A address
data_in  in  DATA_WIDTH  port A write data
data_out  out  DATA_WIDTH  port A registered read data
ld_cs  in  1  port B select
ld_we  in  1  port B write enable (valid with ld_cs)
ld_addr  in  ADDR_WIDTH  port B address
ld_data  in  DATA_WIDTH  port B write data
ld_rdata  out  DATA_WIDTH  port B registered read data
wp_hit  out  1  write to protected range rejected (AIM65_RAM_WP_EN only, else tied 0)

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: data_out=0, ld_rdata=0, busy=1, wp_hit=0, fill counter=0, FSM=INIT. Array contents are not reset.
- FSM states: INIT, READY.
  - INIT: writes FILL to word cnt each cycle; cnt increments.
  - INIT -> READY: on the cycle after cnt=DEPTH-1 is written. busy falls with the READY transition, so a full pass takes exactly DEPTH cycles from reset release.
  - READY -> INIT: on init_req=1; cnt cleared.
  - init_req during INIT: ignored; no restart.
  - reset_n low mid-pass: asynchronous abort; pass restarts from word 0 on release.
- During INIT, both ports:
  - writes are dropped;
  - data_out and ld_rdata load FILL when their cs is high, otherwise hold.
- Read latency (READY): 1 cycle.
  - data_out <= mem[addr] on a cycle with cs=1, and holds when cs=0 (port B likewise).
  - Read-first: a read of an address written in the same cycle returns the old contents.
- Port A write: cs=1 and rw=0.
- Port B write: ld_cs=1 and ld_we=1.
- Collision: both ports write the same address in the same cycle -> port B data is stored; port A write is discarded.
- Out of range (address >= DEPTH): the write is ignored and the read returns FILL. No aliasing/wrap.
- Mapping: address bits above clog2(DEPTH) are decoded, not truncated.
- Inference: must infer a true dual-port block RAM with registered outputs. The init writer shares port B's write path; loader writes are already blocked during INIT, so no conflict.

Optional Feature:
AIM65_RAM_WP_EN
- Defined: port A writes to [WP_BASE, WP_BASE+WP_SIZE-1] are discarded. Used to emulate ROM images loaded via port B.
  - wp_hit pulses high for exactly 1 cycle, on the cycle after the rejected write.
  - Port B and the init sequencer ignore protection.
- Undefined: no range compare logic; wp_hit is a constant 0; WP_BASE and WP_SIZE are unused.

Test Plan:
1. Release reset_n, DEPTH=1024 -> busy high exactly 1024 cycles. Afterwards, port A reads of 0x000, 0x1FF, 0x3FF return 0xFF one cycle after cs.
2. Port A write 0x5A to 0x010, then read 0x010 -> data_out=0x5A one cycle later. Same-cycle write 0x33 / read of 0x010 -> old 0x5A, then 0x33 on the next read.
3. Same cycle: port A writes 0x11 and port B writes 0x22, both to 0x020 -> subsequent read from either port = 0x22.
4. Port A write 0x77 to 0x0400 (>= DEPTH) -> ignored; reading 0x0400 returns 0xFF; word 0x000 is unchanged.
5. Write 0x5A to 0x010, pulse init_req, then assert reset_n low at cycle 300 of the pass. After release -> full 1024-cycle pass; word 0x010 reads 0xFF; port A writes during busy are dropped.
6. With AIM65_RAM_WP_EN, WP_BASE=0x300, WP_SIZE=0x100: port B loads 0xA9 to 0x300, then port A writes 0x00 to 0x300 -> 0x300 still reads 0xA9 and wp_hit pulses for 1 cycle. A port A write to 0x2FF succeeds.

Source files
------------

// File: rtl/aim65_ram_dp.sv
// Dual-port AIM65 work RAM with a hardware fill sequencer on the loader port.
// Optional write protection of a port A window is compiled in with AIM65_RAM_WP_EN.
module aim65_ram_dp #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 1024,
  parameter logic [DATA_WIDTH-1:0] FILL       = 8'hFF,
  parameter int                    WP_BASE    = 0,
  parameter int                    WP_SIZE    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  init_req,
  output logic                  busy,
  input  logic                  cs,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ld_cs,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  wp_hit
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Full-width compare so upper address bits never alias into the array.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [0:0]            state;
  logic [IDX_W-1:0]      cnt;
  logic                  init_act;
  logic                  a_in;
  logic                  b_in;
  logic [IDX_W-1:0]      a_idx;
  logic [IDX_W-1:0]      b_idx;
  logic                  a_wr_req;
  logic                  a_wr_en;
  logic                  b_wr_en;
  logic [IDX_W-1:0]      b_wr_idx;
  logic [DATA_WIDTH-1:0] b_wr_data;
  logic                  wp_block;

  assign init_act = (state == ST_INIT);
  assign busy     = init_act;
  assign a_in     = in_range(addr);
  assign b_in     = in_range(ld_addr);
  assign a_idx    = addr[IDX_W-1:0];
  assign b_idx    = ld_addr[IDX_W-1:0];

  // The fill sequencer borrows port B's write path; loader writes are off while it runs.
  always_comb begin
    b_wr_en   = 1'b0;
    b_wr_idx  = b_idx;
    b_wr_data = ld_data;
    if (init_act) begin
      b_wr_en   = 1'b1;
      b_wr_idx  = cnt;
      b_wr_data = FILL;
    end else if (ld_cs && ld_we && b_in) begin
      b_wr_en = 1'b1;
    end
  end

  assign a_wr_req = !init_act && cs && !rw && a_in;
  // Port B wins a same-address collision, so port A simply stands down.
  assign a_wr_en  = a_wr_req && !wp_block && !(b_wr_en && (b_wr_idx == a_idx));

`ifdef AIM65_RAM_WP_EN
  localparam logic [ADDR_WIDTH:0] WP_LO = (ADDR_WIDTH+1)'(WP_BASE);
  localparam logic [ADDR_WIDTH:0] WP_HI = (ADDR_WIDTH+1)'(WP_BASE + WP_SIZE);

  assign wp_block = (WP_SIZE != 0) && ({1'b0, addr} >= WP_LO) && ({1'b0, addr} < WP_HI);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_hit <= 1'b0;
    end else begin
      wp_hit <= a_wr_req && wp_block;
    end
  end
`else
  logic unused_wp_cfg;

  assign wp_block      = 1'b0;
  assign wp_hit        = 1'b0;
  assign unused_wp_cfg = (WP_BASE == WP_SIZE);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == LAST_IDX) begin
            state <= ST_READY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (init_req) begin
            state <= ST_INIT;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Array storage: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (a_wr_en) begin
      mem[a_idx] <= data_in;
    end
    if (b_wr_en) begin
      mem[b_wr_idx] <= b_wr_data;
    end
  end

  // Registered read-first outputs; FILL while filling or when out of range.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (cs) begin
      data_out <= (init_act || !a_in) ? FILL : mem[a_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_rdata <= '0;
    end else if (ld_cs) begin
      ld_rdata <= (init_act || !b_in) ? FILL : mem[b_idx];
    end
  end

endmodule

// File: tb/tb_aim65_ram_dp.sv
// Directed bench for aim65_ram_dp: fill pass timing, dual-port access, collisions,
// range decode, init restart/abort and (with AIM65_RAM_WP_EN) write protection.
module tb_aim65_ram_dp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        init_req;
  logic        busy;
  logic        cs;
  logic        rw;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        ld_cs;
  logic        ld_we;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic [7:0]  ld_rdata;
  logic        wp_hit;

  int n_tests = 0;
  int n_fail  = 0;

  aim65_ram_dp #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .DEPTH     (1024),
    .FILL      (8'hFF),
    .WP_BASE   ('h300),
    .WP_SIZE   ('h100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .init_req(init_req),
    .busy    (busy),
    .cs      (cs),
    .rw      (rw),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .ld_cs   (ld_cs),
    .ld_we   (ld_we),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .ld_rdata(ld_rdata),
    .wp_hit  (wp_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs;
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        ld_cs;
    logic        ld_we;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        chk_a;
    logic        chk_b;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, id, act, exp);
    end
  endtask

  task automatic drive(input logic a_cs, input logic a_rw, input logic [15:0] a_addr,
                       input logic [7:0] a_din, input logic b_cs, input logic b_we,
                       input logic [15:0] b_addr, input logic [7:0] b_data);
    cs      = a_cs;
    rw      = a_rw;
    addr    = a_addr;
    data_in = a_din;
    ld_cs   = b_cs;
    ld_we   = b_we;
    ld_addr = b_addr;
    ld_data = b_data;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0, 8'h0);
    init_req = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;

    //            cs  rw  addr    din    ldcs ldwe ldaddr  lddata ca   cb   expa   expb
    vecs[0]  = '{1'b1, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h03FF, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[1]  = '{1'b1, 1'b1, 16'h01FF, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[2]  = '{1'b1, 1'b1, 16'h03FF, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 16'h0010, 8'h5A, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h5A, 8'h00};
    vecs[5]  = '{1'b1, 1'b0, 16'h0010, 8'h33, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h5A, 8'h00};
    vecs[6]  = '{1'b1, 1'b1, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'h33, 8'h00};
    vecs[7]  = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 8'h33, 8'hFF};
    vecs[8]  = '{1'b1, 1'b0, 16'h0020, 8'h11, 1'b1, 1'b1, 16'h0020, 8'h22, 1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[9]  = '{1'b1, 1'b1, 16'h0020, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b1, 1'b1, 8'h22, 8'h22};
    vecs[10] = '{1'b1, 1'b0, 16'h0400, 8'h77, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00};
    vecs[11] = '{1'b1, 1'b1, 16'h0400, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[12] = '{1'b1, 1'b1, 16'h03FF, 8'h00, 1'b1, 1'b1, 16'h0401, 8'h44, 1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[13] = '{1'b1, 1'b1, 16'h0410, 8'h00, 1'b1, 1'b0, 16'h0401, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[14] = '{1'b1, 1'b1, 16'h0100, 8'h00, 1'b1, 1'b1, 16'h0100, 8'hC3, 1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[15] = '{1'b1, 1'b1, 16'h0100, 8'h00, 1'b1, 1'b0, 16'h0100, 8'h00, 1'b1, 1'b1, 8'hC3, 8'hC3};
    vecs[16] = '{1'b1, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h33};
    vecs[17] = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h22};

    reset_n = 1'b0;
    idle();
    #12;
    chk("rst_data_out", 0, data_out, 8'h00);
    chk("rst_ld_rdata", 0, ld_rdata, 8'h00);
    chk("rst_busy",     0, busy,     1'b1);
    chk("rst_wp_hit",   0, wp_hit,   1'b0);

    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc = 0;
    while (busy && cyc < 2000) begin
      step();
      cyc++;
    end
    chk("init_len", 0, cyc, 1024);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].cs, vecs[i].rw, vecs[i].addr, vecs[i].din,
            vecs[i].ld_cs, vecs[i].ld_we, vecs[i].ld_addr, vecs[i].ld_data);
      step();
      if (vecs[i].chk_a) chk("vec_a", i, data_out, vecs[i].exp_a);
      if (vecs[i].chk_b) chk("vec_b", i, ld_rdata, vecs[i].exp_b);
      chk("vec_wp", i, wp_hit, 1'b0);
    end
    idle();

    // Re-init pass, aborted by reset 300 cycles in.
    drive(1'b1, 1'b0, 16'h0010, 8'h5A, 1'b0, 1'b0, 16'h0, 8'h0);
    step();
    drive(1'b1, 1'b1, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0, 8'h0);
    step();
    chk("pre_init_rd", 0, data_out, 8'h5A);
    idle();
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    chk("req_busy", 0, busy, 1'b1);
    for (int p = 0; p < 300; p++) begin
      if (p == 10) drive(1'b1, 1'b1, 16'h0020, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00);
      else idle();
      step();
      if (p == 10) begin
        chk("init_rd_a", 0, data_out, 8'hFF);
        chk("init_rd_b", 0, ld_rdata, 8'hFF);
      end
    end
    idle();
    reset_n = 1'b0;
    #2;
    chk("abort_busy", 0, busy,     1'b1);
    chk("abort_dout", 0, data_out, 8'h00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    cyc = 0;
    while (busy && cyc < 2000) begin
      idle();
      if (cyc == 500) init_req = 1'b1;
      if (cyc == 1000) drive(1'b1, 1'b0, 16'h0005, 8'h99, 1'b1, 1'b1, 16'h0006, 8'h88);
      step();
      cyc++;
    end
    idle();
    chk("repass_len", 0, cyc, 1024);

    drive(1'b1, 1'b1, 16'h0010, 8'h00, 1'b1, 1'b0, 16'h0006, 8'h00);
    step();
    chk("refill_010", 0, data_out, 8'hFF);
    chk("drop_b_006", 0, ld_rdata, 8'hFF);
    drive(1'b1, 1'b1, 16'h0005, 8'h00, 1'b1, 1'b0, 16'h0020, 8'h00);
    step();
    chk("drop_a_005", 0, data_out, 8'hFF);
    chk("refill_020", 0, ld_rdata, 8'hFF);

    // Protected window 0x300..0x3FF.
    drive(1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0300, 8'hA9);
    step();
    drive(1'b1, 1'b0, 16'h0300, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
    step();
`ifdef AIM65_RAM_WP_EN
    chk("wp_pulse", 0, wp_hit, 1'b1);
`else
    chk("wp_pulse", 0, wp_hit, 1'b0);
`endif
    drive(1'b1, 1'b0, 16'h02FF, 8'h05, 1'b0, 1'b0, 16'h0000, 8'h00);
    step();
    chk("wp_fall", 0, wp_hit, 1'b0);
    drive(1'b1, 1'b1, 16'h0300, 8'h00, 1'b1, 1'b0, 16'h02FF, 8'h00);
    step();
`ifdef AIM65_RAM_WP_EN
    chk("wp_keep", 0, data_out, 8'hA9);
`else
    chk("wp_keep", 0, data_out, 8'h00);
`endif
    chk("wp_below", 0, ld_rdata, 8'h05);
    chk("wp_quiet", 0, wp_hit, 1'b0);
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
